exec_sequencer: RTL

Multi-cycle sequencer for the NPC core. It fetches an instruction through a valid/ready request and response-valid interface, holds it stable for the decoder/control unit, and sequences the optional load/store memory access. It gates PC and register-file writes to a single write-back cycle and stops the core on ebreak or a bus timeout. It sits between the PC register, instruction memory, LSU and the control/regfile datapath.

---
 rtl/exec_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/execute/memory/write-back sequencer for the NPC core.
// Gates PC and regfile writes to the single WB cycle and stops on ebreak or bus timeout.
module exec_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      pc_i,
    output logic             ifu_req_valid_o,
    input  logic             ifu_req_ready_i,
    output logic [31:0]      ifu_req_addr_o,
    input  logic             ifu_resp_valid_i,
    input  logic [31:0]      ifu_resp_data_i,
    output logic [31:0]      inst_o,
    input  logic             dec_regwen_i,
    input  logic             is_load_i,
    input  logic             is_store_i,
    output logic             lsu_req_valid_o,
    input  logic             lsu_req_ready_i,
    input  logic             lsu_resp_valid_i,
    output logic             pc_we_o,
    output logic             reg_we_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic             halt_o,
    output logic             bus_err_o
);

    localparam logic [31:0] Ebreak = 32'h0010_0073;
    localparam int unsigned TmoW   = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StWaitInst,
        StExec,
        StMemReq,
        StMemWait,
        StWb,
        StHalt,
        StErr
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      inst_q, inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             waiting;
    logic             event_hit;

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        cnt_d     = cnt_q;
        waiting   = 1'b0;
        event_hit = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                waiting   = 1'b1;
                event_hit = ifu_req_ready_i;
                if (event_hit) state_d = StWaitInst;
            end
            StWaitInst: begin
                waiting   = 1'b1;
                event_hit = ifu_resp_valid_i;
                if (event_hit) begin
                    inst_d  = ifu_resp_data_i;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (inst_q == Ebreak) begin
                    state_d = StHalt;
                end else if (is_load_i || is_store_i) begin
                    state_d = StMemReq;
                end else begin
                    state_d = StWb;
                end
            end
            StMemReq: begin
                waiting   = 1'b1;
                event_hit = lsu_req_ready_i;
                if (event_hit) state_d = StMemWait;
            end
            StMemWait: begin
                waiting   = 1'b1;
                event_hit = lsu_resp_valid_i;
                if (event_hit) state_d = StWb;
            end
            StWb: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = StFetch;
            end
            StHalt, StErr: state_d = state_q;
            default: state_d = StIdle;
        endcase

        // An event arriving on the final allowed cycle still wins over the timeout.
        if (waiting && !event_hit && (tmo_q == TmoW'(TIMEOUT - 1))) begin
            state_d = StErr;
        end

        if (state_d != state_q || !waiting) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            inst_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ifu_req_valid_o = (state_q == StFetch);
    assign ifu_req_addr_o  = pc_i;
    assign inst_o          = inst_q;
    assign lsu_req_valid_o = (state_q == StMemReq);
    assign pc_we_o         = (state_q == StWb);
    assign retire_o        = (state_q == StWb);
    assign reg_we_o        = (state_q == StWb) & dec_regwen_i & ~is_store_i;
    assign retired_cnt_o   = cnt_q;
    assign halt_o          = (state_q == StHalt);
    assign bus_err_o       = (state_q == StErr);

endmodule
